// File: rtl/showtank_patrol_if.sv
// Show-sequencer <-> demo-tank bundle: start values and tick in, tank pose and fire pulse out.
interface showtank_patrol_if #(
  parameter int POS_W = 5
);
  logic             enable;
  logic             step_tick;
  logic [POS_W-1:0] start_x;
  logic [POS_W-1:0] start_y;
  logic [1:0]       start_dir;
  logic             shell_state_feedback;
  logic [POS_W-1:0] x_rel_pos_out;
  logic [POS_W-1:0] y_rel_pos_out;
  logic [1:0]       tank_dir_out;
  logic             shell_sht;
  logic             moving;

  modport master (
    output enable, step_tick, start_x, start_y, start_dir, shell_state_feedback,
    input  x_rel_pos_out, y_rel_pos_out, tank_dir_out, shell_sht, moving
  );

  modport slave (
    input  enable, step_tick, start_x, start_y, start_dir, shell_state_feedback,
    output x_rel_pos_out, y_rel_pos_out, tank_dir_out, shell_sht, moving
  );
endinterface

// File: rtl/showtank_patrol.sv
// Attract-mode tank driver: IDLE/LOAD/RUN walker with wrap or bounce edges.
// Optional periodic shell firing is compiled in with `define SHOWTANK_FIRE_EN.
module showtank_patrol #(
  parameter int GRID_W      = 25,
  parameter int GRID_H      = 13,
  parameter int POS_W       = 5,
  parameter int EDGE_MODE   = 0,
  parameter int FIRE_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst,
  showtank_patrol_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int X_MAX_I = GRID_W - 1;
  localparam int Y_MAX_I = GRID_H - 1;
  localparam int ONE_I   = 1;
  localparam logic [POS_W:0] C_X_MAX = X_MAX_I[POS_W:0];
  localparam logic [POS_W:0] C_Y_MAX = Y_MAX_I[POS_W:0];
  localparam logic [POS_W:0] C_ONE   = ONE_I[POS_W:0];

  state_t           r_state;
  logic [POS_W-1:0] r_x;
  logic [POS_W-1:0] r_y;
  logic [1:0]       r_dir;
  logic             r_moving;

  logic [POS_W:0]   w_x_step;
  logic [POS_W:0]   w_y_step;
  logic [POS_W-1:0] w_x_next;
  logic [POS_W-1:0] w_y_next;
  logic [1:0]       w_dir_next;
  logic [POS_W-1:0] w_x_start;
  logic [POS_W-1:0] w_y_start;

  // Next cell one bit wider than the port so a step below 0 lands above the max.
  always_comb begin
    w_x_step   = {1'b0, r_x};
    w_y_step   = {1'b0, r_y};
    w_x_next   = r_x;
    w_y_next   = r_y;
    w_dir_next = r_dir;
    case (r_dir)
      2'b00:   w_y_step = {1'b0, r_y} - C_ONE;
      2'b01:   w_y_step = {1'b0, r_y} + C_ONE;
      2'b10:   w_x_step = {1'b0, r_x} - C_ONE;
      2'b11:   w_x_step = {1'b0, r_x} + C_ONE;
      default: w_x_step = {1'b0, r_x};
    endcase
    if (w_x_step > C_X_MAX) begin
      if (EDGE_MODE == 0) begin
        w_x_next = (r_dir == 2'b10) ? C_X_MAX[POS_W-1:0] : {POS_W{1'b0}};
      end else begin
        w_dir_next = r_dir ^ 2'b01;
      end
    end else if (w_y_step > C_Y_MAX) begin
      if (EDGE_MODE == 0) begin
        w_y_next = (r_dir == 2'b00) ? C_Y_MAX[POS_W-1:0] : {POS_W{1'b0}};
      end else begin
        w_dir_next = r_dir ^ 2'b01;
      end
    end else begin
      w_x_next = w_x_step[POS_W-1:0];
      w_y_next = w_y_step[POS_W-1:0];
    end
    w_x_start = ({1'b0, bus.start_x} > C_X_MAX) ? C_X_MAX[POS_W-1:0] : bus.start_x;
    w_y_start = ({1'b0, bus.start_y} > C_Y_MAX) ? C_Y_MAX[POS_W-1:0] : bus.start_y;
  end

  // Mode FSM with registered pose; a tick in the cycle enable drops still moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_x      <= {POS_W{1'b0}};
      r_y      <= {POS_W{1'b0}};
      r_dir    <= 2'b00;
      r_moving <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_x      <= w_x_start;
          r_y      <= w_y_start;
          r_dir    <= bus.start_dir;
          r_moving <= 1'b1;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          if (bus.step_tick) begin
            r_x   <= w_x_next;
            r_y   <= w_y_next;
            r_dir <= w_dir_next;
          end
          if (!bus.enable) begin
            r_state  <= S_IDLE;
            r_moving <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_rel_pos_out = r_x;
  assign bus.y_rel_pos_out = r_y;
  assign bus.tank_dir_out  = r_dir;
  assign bus.moving        = r_moving;

`ifdef SHOWTANK_FIRE_EN
  localparam int CNT_W       = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
  localparam int CNT_LAST_I  = FIRE_PERIOD - 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_CNT_ONE  = ONE_I[CNT_W-1:0];

  logic [CNT_W-1:0] r_fire_cnt;
  logic             r_pending;
  logic             r_shell_sht;
  logic             w_expire;
  logic             w_fire;

  // Period expiry and the request grant; gating on enable keeps pulses inside RUN.
  always_comb begin
    w_expire = (r_state == S_RUN) && bus.step_tick && (r_fire_cnt == C_CNT_LAST);
    w_fire   = (r_state == S_RUN) && bus.enable && r_pending && !bus.shell_state_feedback;
  end

  // Fire counter and single outstanding request; a fresh expiry wins over a same-cycle grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fire_cnt  <= {CNT_W{1'b0}};
      r_pending   <= 1'b0;
      r_shell_sht <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_fire_cnt  <= {CNT_W{1'b0}};
          r_pending   <= 1'b0;
          r_shell_sht <= 1'b0;
        end
        S_RUN: begin
          r_shell_sht <= w_fire;
          if (bus.step_tick) begin
            r_fire_cnt <= w_expire ? {CNT_W{1'b0}} : (r_fire_cnt + C_CNT_ONE);
          end
          if (!bus.enable) begin
            r_pending <= 1'b0;
          end else if (w_expire) begin
            r_pending <= 1'b1;
          end else if (w_fire) begin
            r_pending <= 1'b0;
          end
        end
        default: begin
          r_pending   <= 1'b0;
          r_shell_sht <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shell_sht = r_shell_sht;
`else
  assign bus.shell_sht = 1'b0;
`endif
endmodule

// File: tb/tb_showtank_patrol.sv
// Directed bench: wrap instance (u_a, FIRE_PERIOD=4) and bounce instance (u_b).
module tb_showtank_patrol;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  showtank_patrol_if #(.POS_W(5)) if_a ();
  showtank_patrol_if #(.POS_W(5)) if_b ();

  showtank_patrol #(.FIRE_PERIOD(4)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  showtank_patrol #(.EDGE_MODE(1), .FIRE_PERIOD(4)) u_b (.clk(clk), .rst(rst), .bus(if_b));

  task automatic start_a(input logic [4:0] sx, input logic [4:0] sy, input logic [1:0] sd);
    if_a.enable = 1'b0;
    @(negedge clk);
    if_a.start_x = sx; if_a.start_y = sy; if_a.start_dir = sd; if_a.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic tick_a();
    if_a.step_tick = 1'b1;
    @(negedge clk);
    if_a.step_tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    repeat (2) @(negedge clk);
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out, if_a.moving};
    n_cmp++;
    if (got !== 13'd0) begin n_err++; $display("FAIL reset_a got=%h exp=0", got); end
    got = {if_b.x_rel_pos_out, if_b.y_rel_pos_out, if_b.tank_dir_out, if_b.moving};
    n_cmp++;
    if (got !== 13'd0 || if_a.shell_sht !== 1'b0) begin
      n_err++; $display("FAIL reset_b got=%h sht=%b exp=0", got, if_a.shell_sht);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [12:0] got;
    start_a(5'd3, 5'd4, 2'b11);
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out, if_a.moving};
    n_cmp++;
    if (got !== {5'd3, 5'd4, 2'b11, 1'b1}) begin n_err++; $display("FAIL basic_load got=%h exp=%h", got, {5'd3, 5'd4, 2'b11, 1'b1}); end
    repeat (3) tick_a();
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out, if_a.moving};
    n_cmp++;
    if (got !== {5'd6, 5'd4, 2'b11, 1'b1}) begin n_err++; $display("FAIL basic_move got=%h exp=%h", got, {5'd6, 5'd4, 2'b11, 1'b1}); end
  endtask

  task automatic test_wrap();
    logic [11:0] got;
    start_a(5'd24, 5'd5, 2'b11);
    tick_a();
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out};
    n_cmp++;
    if (got !== {5'd0, 5'd5, 2'b11}) begin n_err++; $display("FAIL wrap_right1 got=%h exp=%h", got, {5'd0, 5'd5, 2'b11}); end
    tick_a();
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out};
    n_cmp++;
    if (got !== {5'd1, 5'd5, 2'b11}) begin n_err++; $display("FAIL wrap_right2 got=%h exp=%h", got, {5'd1, 5'd5, 2'b11}); end
    start_a(5'd2, 5'd0, 2'b00);
    tick_a();
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out};
    n_cmp++;
    if (got !== {5'd2, 5'd12, 2'b00}) begin n_err++; $display("FAIL wrap_up got=%h exp=%h", got, {5'd2, 5'd12, 2'b00}); end
  endtask

  task automatic test_bounce();
    logic [11:0] got;
    if_b.start_x = 5'd0; if_b.start_y = 5'd7; if_b.start_dir = 2'b10; if_b.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      if_b.step_tick = 1'b1;
      @(negedge clk);
      if_b.step_tick = 1'b0;
      got = {if_b.x_rel_pos_out, if_b.y_rel_pos_out, if_b.tank_dir_out};
      n_cmp++;
      if (got !== {(t == 0) ? 5'd0 : 5'd1, 5'd7, 2'b11}) begin
        n_err++; $display("FAIL bounce_tick%0d got=%h exp=%h", t + 1, got, {(t == 0) ? 5'd0 : 5'd1, 5'd7, 2'b11});
      end
    end
    if_b.enable = 1'b0;
  endtask

`ifdef SHOWTANK_FIRE_EN
  task automatic test_fire();
    int   pulses;
    logic e_sht;
    if_a.shell_state_feedback = 1'b0;
    start_a(5'd5, 5'd5, 2'b11);
    pulses = 0;
    for (int t = 1; t <= 8; t++) begin
      tick_a();
      for (int s = 0; s < 2; s++) begin
        e_sht = (s == 1) && (t % 4 == 0);
        n_cmp++;
        if (if_a.shell_sht !== e_sht) begin n_err++; $display("FAIL fire_t%0d_s%0d got=%b exp=%b", t, s, if_a.shell_sht, e_sht); end
        if (if_a.shell_sht === 1'b1) pulses++;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (if_a.shell_sht !== 1'b0 || pulses != 2) begin
      n_err++; $display("FAIL fire_count got=%0d sht=%b exp=2 sht=0", pulses, if_a.shell_sht);
    end
  endtask

  task automatic test_fire_busy();
    int pulses;
    start_a(5'd5, 5'd5, 2'b11);
    pulses = 0;
    for (int t = 1; t <= 10; t++) begin
      if (t == 3) if_a.shell_state_feedback = 1'b1;
      tick_a();
      for (int s = 0; s < 2; s++) begin
        if (if_a.shell_sht === 1'b1) pulses++;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL busy_hold got=%0d pulses exp=0", pulses); end
    if_a.shell_state_feedback = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (if_a.shell_sht !== 1'b1) begin n_err++; $display("FAIL busy_release got=%b exp=1", if_a.shell_sht); end
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_a.shell_sht === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL busy_single got=%0d extra pulses exp=0", pulses); end
  endtask
`else
  task automatic test_fire_off();
    int pulses;
    start_a(5'd5, 5'd5, 2'b11);
    if_a.shell_state_feedback = 1'b0;
    pulses = 0;
    for (int t = 1; t <= 8; t++) begin
      tick_a();
      if (if_a.shell_sht !== 1'b0) pulses++;
      @(negedge clk);
      if (if_a.shell_sht !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL fire_off got=%0d pulses exp=0", pulses); end
  endtask
`endif

  task automatic test_restart();
    logic [12:0] got;
    start_a(5'd30, 5'd20, 2'b01);
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out, if_a.moving};
    n_cmp++;
    if (got !== {5'd24, 5'd12, 2'b01, 1'b1}) begin n_err++; $display("FAIL clamp got=%h exp=%h", got, {5'd24, 5'd12, 2'b01, 1'b1}); end
    tick_a();
    if_a.enable = 1'b0;
    tick_a();
    repeat (3) tick_a();
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out, if_a.moving};
    n_cmp++;
    if (got !== {5'd24, 5'd1, 2'b01, 1'b0}) begin n_err++; $display("FAIL freeze got=%h exp=%h", got, {5'd24, 5'd1, 2'b01, 1'b0}); end
    if_a.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out, if_a.moving};
    n_cmp++;
    if (got !== {5'd24, 5'd12, 2'b01, 1'b1}) begin n_err++; $display("FAIL reload got=%h exp=%h", got, {5'd24, 5'd12, 2'b01, 1'b1}); end
  endtask

  task automatic test_async_reset();
    logic [13:0] got;
    logic        e_sht;
`ifdef SHOWTANK_FIRE_EN
    e_sht = 1'b1;
`else
    e_sht = 1'b0;
`endif
    if_a.shell_state_feedback = 1'b0;
    start_a(5'd3, 5'd4, 2'b11);
    repeat (4) tick_a();
    if_a.step_tick = 1'b1;
    @(posedge clk);
    #2;
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out, if_a.moving, if_a.shell_sht};
    n_cmp++;
    if (got !== {5'd8, 5'd4, 2'b11, 1'b1, e_sht}) begin n_err++; $display("FAIL pre_rst got=%h exp=%h", got, {5'd8, 5'd4, 2'b11, 1'b1, e_sht}); end
    rst = 1'b1;
    #1;
    got = {if_a.x_rel_pos_out, if_a.y_rel_pos_out, if_a.tank_dir_out, if_a.moving, if_a.shell_sht};
    n_cmp++;
    if (got !== 14'd0) begin n_err++; $display("FAIL async_rst got=%h exp=0", got); end
    @(negedge clk);
    if_a.step_tick = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    if_a.enable = 1'b0; if_a.step_tick = 1'b0; if_a.start_x = 5'd0; if_a.start_y = 5'd0;
    if_a.start_dir = 2'b00; if_a.shell_state_feedback = 1'b0;
    if_b.enable = 1'b0; if_b.step_tick = 1'b0; if_b.start_x = 5'd0; if_b.start_y = 5'd0;
    if_b.start_dir = 2'b00; if_b.shell_state_feedback = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_bounce();
`ifdef SHOWTANK_FIRE_EN
    test_fire();
    test_fire_busy();
`else
    test_fire_off();
`endif
    test_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
